// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
// Included by the APB master and by anything that needs its state encoding.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: takes one valid/ready command at a time, runs SETUP then ACCESS,
// and returns read data, a write completion, or a timeout error on the rsp_* pulse.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    // Last ACCESS cycle allowed without PREADY; the counter never passes it.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    apb_state_t        state_reg, state_next;
    logic [7:0]        wait_cnt_reg, wait_cnt_next;
    logic              psel_reg, psel_next;
    logic              penable_reg, penable_next;
    logic              pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic [DATA_W-1:0] pwdata_reg, pwdata_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg     <= APB_IDLE;
            wait_cnt_reg  <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = '0;
        rsp_err_next   = 1'b0;

        case (state_reg)
            APB_IDLE: begin
                if (cmd_valid) begin
                    pwrite_next = cmd_write;
                    paddr_next  = cmd_addr;
                    pwdata_next = cmd_wdata;
                    psel_next   = 1'b1;
                    state_next  = APB_SETUP;
                end
            end
            APB_SETUP: begin
                // PREADY is deliberately not looked at here, so a level left
                // over from the previous transfer cannot end this one early.
                psel_next     = 1'b1;
                penable_next  = 1'b1;
                wait_cnt_next = '0;
                state_next    = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = pwrite_reg ? '0 : PRDATA;
                    state_next     = APB_IDLE;
                end else if (wait_cnt_reg >= WAIT_LAST) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    state_next     = APB_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    psel_next     = 1'b1;
                    penable_next  = 1'b1;
                end
            end
            default: begin
                state_next = APB_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == APB_IDLE) && !PRESET;
    assign PSEL      = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = pwrite_reg;
    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
